// File: rtl/gx4000_mapper_pkg.sv
// gx4000_mapper_pkg
//   Shared definitions for the GX4000 bank mapper: fault codes, page
//   protection encodings, transaction FSM states, the CPU write-request
//   record and the I/O register index map.
package gx4000_mapper_pkg;

    typedef enum logic [7:0] {
        FLT_NONE      = 8'd0,
        FLT_PROTECTED = 8'd1,
        FLT_LOCKED    = 8'd3,
        FLT_BUSY      = 8'd4,
        FLT_TIMEOUT   = 8'd5
    } fault_e;

    typedef enum logic [1:0] {
        PROT_NONE  = 2'd0,
        PROT_NO_RD = 2'd1,
        PROT_NO_WR = 2'd2,
        PROT_ALL   = 2'd3
    } prot_e;

    typedef enum logic [1:0] {
        TXN_IDLE,
        TXN_REQ,
        TXN_DENY,
        TXN_RESP
    } txn_state_e;

    // Write half of a CPU access, latched at the strobe.
    typedef struct packed {
        logic       we;
        logic [7:0] wdata;
    } cpu_req_t;

    // Register map: bank_base[0..np-1], protect[np..2np-1], CTRL, EXP_BANK,
    // FAULT, then one counter per page.
    function automatic int unsigned reg_protect(int unsigned np, int unsigned p);
        return np + p;
    endfunction
    function automatic int unsigned reg_ctrl(int unsigned np);
        return 2 * np;
    endfunction
    function automatic int unsigned reg_exp_bank(int unsigned np);
        return 2 * np + 1;
    endfunction
    function automatic int unsigned reg_fault(int unsigned np);
        return 2 * np + 2;
    endfunction
    function automatic int unsigned reg_count(int unsigned np, int unsigned p);
        return 2 * np + 3 + p;
    endfunction

    // Bit 0 blocks reads, bit 1 blocks writes.
    function automatic logic prot_denied(logic [1:0] prot, logic is_wr);
        return is_wr ? prot[1] : prot[0];
    endfunction

endpackage

// File: rtl/gx4000_mem_txn.sv
// gx4000_mem_txn
//   Request/acknowledge handshake for one CPU access, with abort after
//   TIMEOUT cycles without mem_ack.
//   start/deny  : accepted access (allowed / refused by protection)
//   mem_req     : request held while waiting for mem_ack
//   busy/done   : transaction in flight / one-cycle completion pulse
//   ack_hit     : ack taken this cycle; timeout_hit: abort this cycle
//   rdata       : mem_q on ack, 8'hFF on refusal or timeout
module gx4000_mem_txn #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic       deny,
    input  logic       mem_ack,
    input  logic [7:0] mem_q,
    output logic       mem_req,
    output logic       busy,
    output logic       done,
    output logic       ack_hit,
    output logic       timeout_hit,
    output logic [7:0] rdata
);
    import gx4000_mapper_pkg::*;

    localparam int TCW = $clog2(TIMEOUT);
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);

    txn_state_e     state, state_nxt;
    logic [TCW-1:0] tcnt;

    assign mem_req     = (state == TXN_REQ);
    assign busy        = (state != TXN_IDLE);
    assign done        = (state == TXN_RESP);
    assign ack_hit     = mem_req && mem_ack;
    // An ack on the last allowed cycle still wins over the abort.
    assign timeout_hit = mem_req && !mem_ack && (tcnt == T_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            TXN_IDLE: if (start) state_nxt = TXN_REQ;
                      else if (deny) state_nxt = TXN_DENY;
            TXN_REQ:  if (ack_hit || timeout_hit) state_nxt = TXN_RESP;
            // Refused accesses idle one cycle so they finish two cycles
            // after the strobe, like the fastest acked access.
            TXN_DENY: state_nxt = TXN_RESP;
            TXN_RESP: state_nxt = TXN_IDLE;
            default:  state_nxt = TXN_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= TXN_IDLE;
            tcnt  <= '0;
            rdata <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= mem_req ? tcnt + TCW'(1) : '0;
            if (ack_hit)
                rdata <= mem_q;
            else if (timeout_hit || deny)
                rdata <= 8'hFF;
        end
    end

endmodule

// File: rtl/gx4000_bank_mapper.sv
// gx4000_bank_mapper
//   Plus/GX4000 memory mapper: per-page bank translation of CPU addresses
//   to cartridge/SDRAM or expansion RAM, page protection, fault latch and
//   saturating per-page access counters.
//   cpu_*   : strobed CPU access in, rdata/busy/done out
//   io_*    : configuration register port, read data one cycle after io_rd
//   mem_*   : request/ack port to the SDRAM arbiter
//   exp_*   : expansion-RAM target flag and address for the current request
//   fault*  : latched fault code and level interrupt
module gx4000_bank_mapper #(
    parameter int PAGE_BITS  = 14,
    parameter int BANK_W     = 8,
    parameter int MEM_AW     = BANK_W + PAGE_BITS,
    parameter int EXP_BANK_W = 5,
    parameter int EXP_AW     = EXP_BANK_W + PAGE_BITS,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    input  logic [7:0]        io_addr,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [7:0]        io_wdata,
    output logic [7:0]        io_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_q,
    output logic              exp_sel,
    output logic [EXP_AW-1:0] exp_addr,
    output logic [7:0]        fault,
    output logic              fault_irq
);
    import gx4000_mapper_pkg::*;

    localparam int NUM_PAGES = 2 ** (16 - PAGE_BITS);
    localparam int PG_W      = 16 - PAGE_BITS;

    logic [NUM_PAGES-1:0][BANK_W-1:0] bank_base;
    logic [NUM_PAGES-1:0][1:0]        protect;
    logic [NUM_PAGES-1:0][7:0]        count;
    logic                             lock, exp_en;
    logic [EXP_BANK_W-1:0]            exp_bank;
    logic [7:0]                       fault_q, rd_mux;
    logic [31:0]                      io_idx;

    logic [PG_W-1:0]      page, page_q;
    logic [PAGE_BITS-1:0] offset;
    logic                 xsel_q;
    cpu_req_t             req_q;
    logic accept, denied, txn_start, txn_deny, busy_hit, lock_hit;
    logic ack_hit, timeout_hit;

    assign io_idx = {24'd0, io_addr};
    assign page   = cpu_addr[15:PAGE_BITS];
    assign offset = cpu_addr[PAGE_BITS-1:0];

    // All decisions use the register values from before any same-cycle
    // configuration write.
    assign accept    = enable && (cpu_rd || cpu_wr) && !cpu_busy;
    assign busy_hit  = enable && (cpu_rd || cpu_wr) && cpu_busy;
    assign denied    = prot_denied(protect[page], cpu_wr);
    assign txn_start = accept && !denied;
    assign txn_deny  = accept && denied;
    assign lock_hit  = io_wr && lock &&
                       (io_idx < reg_ctrl(NUM_PAGES) || io_idx == reg_exp_bank(NUM_PAGES));

    gx4000_mem_txn #(.TIMEOUT(TIMEOUT)) u_txn (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .start       (txn_start),
        .deny        (txn_deny),
        .mem_ack     (mem_ack),
        .mem_q       (mem_q),
        .mem_req     (mem_req),
        .busy        (cpu_busy),
        .done        (cpu_done),
        .ack_hit     (ack_hit),
        .timeout_hit (timeout_hit),
        .rdata       (cpu_rdata)
    );

    // Translation captured at the strobe and held for the whole request.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr <= '0;
            exp_addr <= '0;
            xsel_q   <= 1'b0;
            req_q    <= '0;
            page_q   <= '0;
        end else if (txn_start) begin
            mem_addr <= MEM_AW'({bank_base[page], offset});
            exp_addr <= EXP_AW'({exp_bank, offset});
            xsel_q   <= exp_en && (&page);
            req_q    <= '{we: cpu_wr, wdata: cpu_wdata};
            page_q   <= page;
        end
    end

    assign mem_we    = mem_req && req_q.we;
    assign mem_wdata = req_q.wdata;
    assign exp_sel   = mem_req && xsel_q;

    // Configuration registers; the lock only freezes the mapping itself.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bank_base <= '0;
            protect   <= '0;
            exp_bank  <= '0;
            lock      <= 1'b0;
            exp_en    <= 1'b0;
        end else if (io_wr) begin
            if (!lock) begin
                for (int unsigned p = 0; p < NUM_PAGES; p++) begin
                    if (io_idx == p) bank_base[p] <= BANK_W'(io_wdata);
                    if (io_idx == reg_protect(NUM_PAGES, p)) protect[p] <= io_wdata[1:0];
                end
                if (io_idx == reg_exp_bank(NUM_PAGES)) exp_bank <= EXP_BANK_W'(io_wdata);
            end
            if (io_idx == reg_ctrl(NUM_PAGES)) begin
                lock   <= io_wdata[0];
                exp_en <= io_wdata[1];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count <= '0;
        end else begin
            for (int p = 0; p < NUM_PAGES; p++)
                if (ack_hit && page_q == PG_W'(p) && count[p] != 8'hFF)
                    count[p] <= count[p] + 8'd1;
        end
    end

    // A new fault always beats a clear written in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset)                                        fault_q <= FLT_NONE;
        else if (timeout_hit)                             fault_q <= FLT_TIMEOUT;
        else if (txn_deny)                                fault_q <= FLT_PROTECTED;
        else if (busy_hit)                                fault_q <= FLT_BUSY;
        else if (lock_hit)                                fault_q <= FLT_LOCKED;
        else if (io_wr && io_idx == reg_fault(NUM_PAGES)) fault_q <= FLT_NONE;
    end

    assign fault     = fault_q;
    assign fault_irq = |fault_q;

    always_comb begin
        rd_mux = '0;
        for (int unsigned p = 0; p < NUM_PAGES; p++) begin
            if (io_idx == p)                         rd_mux = 8'(bank_base[p]);
            if (io_idx == reg_protect(NUM_PAGES, p)) rd_mux = {6'd0, protect[p]};
            if (io_idx == reg_count(NUM_PAGES, p))   rd_mux = count[p];
        end
        if (io_idx == reg_ctrl(NUM_PAGES))     rd_mux = {6'd0, exp_en, lock};
        if (io_idx == reg_exp_bank(NUM_PAGES)) rd_mux = 8'(exp_bank);
        if (io_idx == reg_fault(NUM_PAGES))    rd_mux = fault_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)      io_rdata <= '0;
        else if (io_rd) io_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_gx4000_bank_mapper.sv
module tb_gx4000_bank_mapper;
    localparam int PAGE_BITS = 14, BANK_W = 8, MEM_AW = 22, EXP_BANK_W = 5, EXP_AW = 19;
    localparam int TIMEOUT = 64;
    localparam int NP = 4, R_CTRL = 8, R_EXP = 9, R_FAULT = 10, R_CNT = 11;
    localparam int NOACK = -1, LATE = -2;

    logic clk_sys = 0, reset, enable, cpu_rd, cpu_wr, io_wr, io_rd, mem_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata, io_addr, io_wdata, io_rdata, mem_wdata, mem_q, fault;
    logic        cpu_busy, cpu_done, mem_req, mem_we, exp_sel, fault_irq;
    logic [MEM_AW-1:0] mem_addr;
    logic [EXP_AW-1:0] exp_addr;

    gx4000_bank_mapper #(.PAGE_BITS(PAGE_BITS), .BANK_W(BANK_W), .MEM_AW(MEM_AW),
                         .EXP_BANK_W(EXP_BANK_W), .EXP_AW(EXP_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset), .enable(enable),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
        .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_q(mem_q), .exp_sel(exp_sel), .exp_addr(exp_addr),
        .fault(fault), .fault_irq(fault_irq));

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] rdata;
        logic       chk_rd;
        int         t0;
        int         lat;
    } resp_t;

    typedef struct {
        logic [MEM_AW-1:0] addr;
        logic              xsel;
        logic [EXP_AW-1:0] xaddr;
        logic              we;
        logic [7:0]        wdata;
        int                delay;
        logic [7:0]        data;
    } mreq_t;

    resp_t resp_q[$];
    mreq_t mreq_q[$];

    // Reference model of the mapper's architectural state.
    int m_bank[NP], m_prot[NP], m_cnt[NP];
    int m_lock, m_expen, m_expbank, m_fault;

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin m_bank[p] = 0; m_prot[p] = 0; m_cnt[p] = 0; end
        m_lock = 0; m_expen = 0; m_expbank = 0; m_fault = 0;
    endtask

    function automatic int model_reg(input int idx);
        if (idx < NP)              return m_bank[idx];
        if (idx < 2 * NP)          return m_prot[idx - NP];
        if (idx == R_CTRL)         return m_expen * 2 + m_lock;
        if (idx == R_EXP)          return m_expbank;
        if (idx == R_FAULT)        return m_fault;
        if (idx < R_CNT + NP)      return m_cnt[idx - R_CNT];
        return 0;
    endfunction

    // Completion monitor: every cpu_done must match the oldest expectation.
    always @(negedge clk_sys) begin
        resp_t r;
        if (!reset && cpu_done) begin
            if (resp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: cpu_done at cycle %0d, expected none", cyc);
            end else begin
                r = resp_q.pop_front();
                chk("done_latency", cyc - r.t0, r.lat);
                if (r.chk_rd) chk("cpu_rdata", cpu_rdata, r.rdata);
            end
        end
    end

    // Memory responder: checks each request against the expected one and acks.
    initial begin
        mreq_t m;
        int n;
        mem_ack = 0; mem_q = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset && mem_req) begin
                if (mreq_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_mem_req: mem_req=1 addr %0h, expected no request", mem_addr);
                    n = 0;
                    while (mem_req && n < TIMEOUT + 8) begin @(negedge clk_sys); n++; end
                end else begin
                    m = mreq_q.pop_front();
                    chk("exp_sel", exp_sel, m.xsel);
                    if (m.xsel) chk("exp_addr", exp_addr, m.xaddr);
                    else        chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", mem_we, m.we);
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                    if (m.delay >= 0) begin
                        repeat (m.delay) @(negedge clk_sys);
                        mem_ack = 1; mem_q = m.data;
                        @(negedge clk_sys);
                        mem_ack = 0; mem_q = 0;
                    end else begin
                        n = 0;
                        while (mem_req && n < TIMEOUT + 8) begin @(negedge clk_sys); n++; end
                        chk("mem_req_dropped", mem_req, 0);
                        if (m.delay == LATE) begin
                            @(negedge clk_sys);
                            mem_ack = 1; mem_q = 8'h5A;
                            @(negedge clk_sys);
                            mem_ack = 0; mem_q = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic io_write(input int idx, input int d);
        io_addr = 8'(idx); io_wdata = 8'(d); io_wr = 1;
        @(negedge clk_sys);
        io_wr = 0;
        if (idx < 2 * NP || idx == R_EXP) begin
            if (m_lock != 0)    m_fault = 3;
            else if (idx < NP)  m_bank[idx] = d & 255;
            else if (idx < 2*NP) m_prot[idx - NP] = d & 3;
            else                m_expbank = d & 31;
        end else if (idx == R_CTRL) begin
            m_lock = d & 1; m_expen = (d >> 1) & 1;
        end else if (idx == R_FAULT) begin
            m_fault = 0;
        end
    endtask

    task automatic io_check(input string name, input int idx);
        io_addr = 8'(idx); io_rd = 1;
        @(negedge clk_sys);
        io_rd = 0;
        chk($sformatf("%s[%0d]", name, idx), io_rdata, model_reg(idx));
    endtask

    // One CPU access; dbl issues a second strobe while the first is in flight.
    task automatic cpu_access(input logic [15:0] addr, input logic wr, input logic [7:0] wd,
                              input int delay, input bit dbl);
        int p, off, n;
        bit den;
        resp_t r;
        mreq_t m;
        p   = int'(addr) >> PAGE_BITS;
        off = int'(addr) % (1 << PAGE_BITS);
        den = wr ? (m_prot[p] == 2 || m_prot[p] == 3) : (m_prot[p] == 1 || m_prot[p] == 3);
        r.t0 = cyc; r.chk_rd = !wr;
        if (den) begin
            r.lat = 2; r.rdata = 8'hFF; r.chk_rd = 1; m_fault = 1;
        end else begin
            m.addr  = MEM_AW'(m_bank[p] * (1 << PAGE_BITS) + off);
            m.xsel  = (m_expen != 0) && (p == NP - 1);
            m.xaddr = EXP_AW'(m_expbank * (1 << PAGE_BITS) + off);
            m.we = wr; m.wdata = wd; m.delay = delay; m.data = 8'($urandom);
            mreq_q.push_back(m);
            if (delay == NOACK) begin
                r.lat = TIMEOUT + 1; r.rdata = 8'hFF; r.chk_rd = 1; m_fault = 5;
            end else begin
                r.lat = 2 + delay; r.rdata = m.data;
                if (m_cnt[p] < 255) m_cnt[p]++;
            end
        end
        resp_q.push_back(r);
        cpu_addr = addr; cpu_wdata = wd; cpu_wr = wr; cpu_rd = !wr;
        @(negedge clk_sys);
        cpu_rd = 0; cpu_wr = 0;
        chk("cpu_busy", cpu_busy, 1);
        if (dbl) begin
            cpu_addr = 16'h0040; cpu_rd = 1;
            @(negedge clk_sys);
            cpu_rd = 0; m_fault = 4;
        end
        n = 0;
        while (cpu_busy && n < TIMEOUT + 20) begin @(negedge clk_sys); n++; end
        if (cpu_busy) begin
            tests++; fails++;
            $display("FAIL busy_timeout: cpu_busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mreq_t m;
        reset = 1; enable = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        io_wr = 0; io_rd = 0; io_addr = 0; io_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        reset = 0;
        @(negedge clk_sys);

        chk("rst_mem_req", mem_req, 0);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_irq", fault_irq, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_exp_sel", exp_sel, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_io_rdata", io_rdata, 0);

        // Basic translated read.
        io_write(2, 8'h15);
        cpu_access(16'h8123, 0, 8'h00, 2, 0);
        io_check("count", R_CNT + 2);

        // Write-protected page.
        io_write(NP + 1, 2);
        cpu_access(16'h4000, 1, 8'h77, 0, 0);
        chk("fault_prot", fault, m_fault);
        chk("fault_irq_set", fault_irq, 1);
        io_write(R_FAULT, 0);
        io_check("fault_clr", R_FAULT);
        chk("fault_irq_clr", fault_irq, 0);

        // Expansion RAM window and lock.
        io_write(R_EXP, 8'h03);
        io_write(R_CTRL, 3);
        cpu_access(16'hC010, 0, 8'h00, 1, 0);
        io_write(0, 8'h99);
        io_check("fault_lock", R_FAULT);
        io_check("bank_locked", 0);
        io_write(R_CTRL, 0);

        // Timeout.
        cpu_access(16'h0100, 0, 8'h00, NOACK, 0);
        io_check("fault_timeout", R_FAULT);

        // Strobe while busy.
        cpu_access(16'h8001, 0, 8'h00, 3, 1);
        io_check("fault_busy", R_FAULT);

        // Counter saturation on page 0.
        for (int i = 0; i < 256; i++)
            cpu_access(16'($urandom_range(0, 16'h3FFF)), 0, 8'h00, 0, 0);
        io_check("count_sat", R_CNT);

        // Randomized mapping and accesses.
        for (int p = 0; p < NP; p++) begin
            io_write(p, $urandom_range(0, 255));
            io_write(NP + p, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
        end
        io_write(R_EXP, $urandom_range(0, 31));
        io_write(R_CTRL, $urandom_range(0, 1) * 2);
        for (int i = 0; i < 60; i++) begin
            int d;
            logic wr;
            d  = ($urandom_range(0, 11) == 0) ? NOACK : $urandom_range(0, 4);
            wr = 1'($urandom_range(0, 1));
            cpu_access(16'($urandom), wr, 8'($urandom), d, 0);
            io_check("rnd_fault", R_FAULT);
            if ($urandom_range(0, 3) == 0) io_write(R_FAULT, 0);
            if ($urandom_range(0, 7) == 0) begin
                enable = 0; cpu_rd = 1; cpu_addr = 16'($urandom);
                @(negedge clk_sys);
                cpu_rd = 0; enable = 1;
                repeat (3) @(negedge clk_sys);
                chk("disabled_busy", cpu_busy, 0);
                chk("disabled_fault", fault, m_fault);
            end
        end
        for (int p = 0; p < NP; p++) io_check("rnd_count", R_CNT + p);
        for (int p = 0; p < 2 * NP; p++) io_check("rnd_cfg", p);

        // Reset in the middle of a request.
        io_write(R_CTRL, 0);
        io_write(NP, 0);
        m.addr = MEM_AW'(m_bank[0] * (1 << PAGE_BITS) + 16'h0010);
        m.xsel = 0; m.xaddr = 0; m.we = 0; m.wdata = 0; m.delay = LATE; m.data = 0;
        mreq_q.push_back(m);
        cpu_addr = 16'h0010; cpu_rd = 1;
        @(negedge clk_sys);
        cpu_rd = 0;
        repeat (2) @(negedge clk_sys);
        chk("mem_req_before_reset", mem_req, 1);
        reset = 1;
        @(negedge clk_sys);
        chk("mem_req_after_reset", mem_req, 0);
        reset = 0;
        model_reset();
        repeat (6) @(negedge clk_sys);
        chk("post_reset_busy", cpu_busy, 0);
        io_check("post_reset_count", R_CNT);
        io_check("post_reset_fault", R_FAULT);

        repeat (4) @(negedge clk_sys);
        chk("resp_q_empty", resp_q.size(), 0);
        chk("mreq_q_empty", mreq_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
